// File: rtl/trap_sequencer.sv
// Machine-mode trap controller at the writeback boundary.
// Sequences mepc/mcause writes, flushes the pipe and redirects fetch.
module trap_sequencer #(
  parameter int XLEN = 64,
  parameter int PC_W = 32,
  parameter logic [XLEN-1:0] CAUSE_ECALL = 64'd11,
  parameter logic [XLEN-1:0] CAUSE_MTI = 64'h8000_0000_0000_0007
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [PC_W-1:0] wb_pc,
  input  logic [PC_W-1:0] wb_next_pc,
  input  logic            wb_ecall,
  input  logic            wb_mret,
  input  logic            wb_csr_we,
  input  logic [11:0]     wb_csr_addr,
  input  logic [XLEN-1:0] wb_csr_wdata,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mie,
  input  logic            timer_irq,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            mstatus_enter,
  output logic            mstatus_exit,
  output logic            flush,
  output logic            wb_stall,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    REDIRECT
  } state_t;

  state_t state, next;

  logic [PC_W-1:0] epc;
  logic [XLEN-1:0] cause;
  logic [PC_W-1:0] target;

  logic idle, irq_take;
  logic take_ecall, take_mret, take_irq;
  logic pass_we;
  logic [PC_W-1:0] vec;

  assign idle = (state == IDLE);
  assign irq_take = timer_irq && csr_mstatus[3] && csr_mie[7];
  assign take_ecall = idle && wb_valid && wb_ecall;
  assign take_mret = idle && wb_valid && !wb_ecall && wb_mret;
  assign take_irq = idle && wb_valid && !wb_ecall && !wb_mret && irq_take;
  assign pass_we = wb_valid && wb_csr_we;
  assign vec = {csr_mtvec[PC_W-1:2], 2'b00};

  // Vectored mode is not supported, so the mode bits are dropped.
  logic unused_ok;
  assign unused_ok = ^{csr_mtvec[XLEN-1:PC_W], csr_mtvec[1:0],
                       csr_mepc[XLEN-1:PC_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      epc <= '0;
      cause <= '0;
      target <= '0;
    end else begin
      state <= next;
      unique case (1'b1)
        take_ecall: begin
          epc <= wb_pc;
          cause <= CAUSE_ECALL;
          target <= vec;
        end
        take_mret: begin
          target <= csr_mepc[PC_W-1:0];
        end
        take_irq: begin
          epc <= wb_next_pc;
          cause <= CAUSE_MTI;
          target <= vec;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next = state;
    csr_we = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    mstatus_enter = 1'b0;
    mstatus_exit = 1'b0;
    flush = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    unique case (state)
      IDLE: begin
        csr_we = pass_we;
        if (pass_we) begin
          csr_waddr = wb_csr_addr;
          csr_wdata = wb_csr_wdata;
        end
        unique case (1'b1)
          take_ecall: begin
            flush = 1'b1;
            next = SAVE_EPC;
          end
          take_mret: begin
            flush = 1'b1;
            mstatus_exit = 1'b1;
            next = REDIRECT;
          end
          take_irq: begin
            flush = 1'b1;
            next = SAVE_EPC;
          end
          default: ;
        endcase
      end
      SAVE_EPC: begin
        flush = 1'b1;
        csr_we = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = {{(XLEN-PC_W){1'b0}}, epc};
        next = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        flush = 1'b1;
        csr_we = 1'b1;
        csr_waddr = 12'h342;
        csr_wdata = cause;
        mstatus_enter = 1'b1;
        next = REDIRECT;
      end
      REDIRECT: begin
        flush = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = target;
        if (redirect_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign wb_stall = !idle;
  assign busy = !idle;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed and random checks of trap_sequencer against a
// queue-of-pending-actions reference model.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_next_pc;
  logic        wb_ecall;
  logic        wb_mret;
  logic        wb_csr_we;
  logic [11:0] wb_csr_addr;
  logic [63:0] wb_csr_wdata;
  logic [63:0] csr_mtvec;
  logic [63:0] csr_mepc;
  logic [63:0] csr_mstatus;
  logic [63:0] csr_mie;
  logic        timer_irq;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        mstatus_enter;
  logic        mstatus_exit;
  logic        flush;
  logic        wb_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk(clk),
    .rst(rst),
    .wb_valid(wb_valid),
    .wb_pc(wb_pc),
    .wb_next_pc(wb_next_pc),
    .wb_ecall(wb_ecall),
    .wb_mret(wb_mret),
    .wb_csr_we(wb_csr_we),
    .wb_csr_addr(wb_csr_addr),
    .wb_csr_wdata(wb_csr_wdata),
    .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc),
    .csr_mstatus(csr_mstatus),
    .csr_mie(csr_mie),
    .timer_irq(timer_irq),
    .csr_we(csr_we),
    .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata),
    .mstatus_enter(mstatus_enter),
    .mstatus_exit(mstatus_exit),
    .flush(flush),
    .wb_stall(wb_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .busy(busy)
  );

  // One entry per cycle of pending trap activity; a redirect entry
  // stays at the head until fetch accepts it.
  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
    logic        enter;
    logic        rv;
    logic [31:0] rpc;
  } act_t;

  act_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic act_t mk(input logic we, input logic [11:0] a,
                              input logic [63:0] d, input logic en,
                              input logic rv, input logic [31:0] pc);
    act_t r;
    r.we = we;
    r.addr = a;
    r.data = d;
    r.enter = en;
    r.rv = rv;
    r.rpc = pc;
    return r;
  endfunction

  function automatic logic irq_ok();
    return timer_irq && csr_mstatus[3] && csr_mie[7];
  endfunction

  task automatic settle();
    act_t h;
    logic e_we, e_en, e_ex, e_fl, e_rv, e_busy;
    logic [11:0] e_addr;
    logic [63:0] e_data;
    logic [31:0] e_rpc;
    #1;
    if (q.size() != 0) begin
      h = q[0];
      e_busy = 1'b1;
      e_fl = 1'b1;
      e_ex = 1'b0;
      e_we = h.we;
      e_addr = h.addr;
      e_data = h.data;
      e_en = h.enter;
      e_rv = h.rv;
      e_rpc = h.rpc;
    end else begin
      e_busy = 1'b0;
      e_we = wb_csr_we && wb_valid;
      e_addr = wb_csr_addr;
      e_data = wb_csr_wdata;
      e_en = 1'b0;
      e_rv = 1'b0;
      e_rpc = '0;
      e_ex = wb_valid && !wb_ecall && wb_mret;
      e_fl = wb_valid && (wb_ecall || wb_mret || irq_ok());
    end
    chk("busy", busy, e_busy);
    chk("wb_stall", wb_stall, e_busy);
    chk("flush", flush, e_fl);
    chk("csr_we", csr_we, e_we);
    if (e_we) begin
      chk("csr_waddr", csr_waddr, e_addr);
      chk("csr_wdata", csr_wdata, e_data);
    end
    chk("mstatus_enter", mstatus_enter, e_en);
    chk("mstatus_exit", mstatus_exit, e_ex);
    chk("redirect_valid", redirect_valid, e_rv);
    if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  task automatic advance();
    logic [31:0] vec;
    @(posedge clk);
    vec = csr_mtvec[31:0] & 32'hffff_fffc;
    if (q.size() != 0) begin
      if (!q[0].rv || redirect_ready) void'(q.pop_front());
    end else if (wb_valid) begin
      if (wb_ecall) begin
        q.push_back(mk(1, 12'h341, 64'(wb_pc), 0, 0, 0));
        q.push_back(mk(1, 12'h342, 64'd11, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 1, vec));
      end else if (wb_mret) begin
        q.push_back(mk(0, 0, 0, 0, 1, csr_mepc[31:0]));
      end else if (irq_ok()) begin
        q.push_back(mk(1, 12'h341, 64'(wb_next_pc), 0, 0, 0));
        q.push_back(mk(1, 12'h342, 64'h8000_0000_0000_0007, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 1, vec));
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic quiet();
    wb_valid = 0;
    wb_ecall = 0;
    wb_mret = 0;
    wb_csr_we = 0;
  endtask

  initial begin
    rst = 0;
    quiet();
    wb_pc = 0;
    wb_next_pc = 0;
    wb_csr_addr = 0;
    wb_csr_wdata = 0;
    csr_mtvec = 0;
    csr_mepc = 0;
    csr_mstatus = 0;
    csr_mie = 0;
    timer_irq = 0;
    redirect_ready = 0;
    settle();
    @(negedge clk);
    rst = 1;
    step();

    // CSR-instruction passthrough
    wb_valid = 1;
    wb_csr_we = 1;
    wb_csr_addr = 12'h305;
    wb_csr_wdata = 64'h1234;
    settle();
    chk("pass_we", csr_we, 1);
    chk("pass_addr", csr_waddr, 12'h305);
    chk("pass_data", csr_wdata, 64'h1234);
    advance();
    quiet();

    // ecall
    wb_pc = 32'h8000_0100;
    csr_mtvec = 64'h8000_0003;
    redirect_ready = 1;
    wb_valid = 1;
    wb_ecall = 1;
    step();
    quiet();
    settle();
    chk("ecall_epc", csr_wdata, 64'h8000_0100);
    advance();
    settle();
    chk("ecall_cause", csr_wdata, 64'd11);
    advance();
    settle();
    chk("ecall_rpc", redirect_pc, 32'h8000_0000);
    advance();
    settle();
    chk("ecall_idle", busy, 0);
    advance();

    // Timer interrupt on a plain instruction
    csr_mstatus = 64'h8;
    csr_mie = 64'h80;
    timer_irq = 1;
    wb_valid = 1;
    wb_next_pc = 32'h8000_0204;
    step();
    quiet();
    timer_irq = 0;
    settle();
    chk("irq_epc", csr_wdata, 64'h8000_0204);
    advance();
    settle();
    chk("irq_cause", csr_wdata, 64'h8000_0000_0000_0007);
    advance();
    step();
    step();

    // Masked, then enabled
    csr_mstatus = 0;
    timer_irq = 1;
    wb_valid = 1;
    step();
    step();
    csr_mstatus = 64'h8;
    settle();
    chk("unmask_flush", flush, 1);
    advance();
    quiet();
    repeat (4) step();

    // mret with an enabled interrupt pending (deferred)
    csr_mepc = 64'h8000_0104;
    redirect_ready = 0;
    wb_valid = 1;
    wb_mret = 1;
    step();
    quiet();
    repeat (3) begin
      settle();
      chk("mret_rpc", redirect_pc, 32'h8000_0104);
      advance();
    end
    redirect_ready = 1;
    step();
    timer_irq = 0;
    step();

    // ecall wins over a pending interrupt, which follows afterwards
    timer_irq = 1;
    wb_valid = 1;
    wb_ecall = 1;
    step();
    quiet();
    repeat (3) step();
    wb_valid = 1;
    wb_next_pc = 32'h8000_0300;
    step();
    quiet();
    timer_irq = 0;
    repeat (4) step();

    // Asynchronous reset during SAVE_CAUSE
    wb_valid = 1;
    wb_ecall = 1;
    step();
    quiet();
    step();
    #2 rst = 0;
    #1;
    chk("rst_csr_we", csr_we, 0);
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enter", mstatus_enter, 0);
    chk("rst_rv", redirect_valid, 0);
    q.delete();
    @(negedge clk);
    rst = 1;
    repeat (3) step();

    // Random traffic
    repeat (400) begin
      wb_valid = ($urandom_range(0, 9) < 7);
      wb_ecall = ($urandom_range(0, 9) == 0);
      wb_mret = ($urandom_range(0, 9) == 0);
      wb_csr_we = ($urandom_range(0, 9) < 3);
      wb_csr_addr = 12'($urandom);
      wb_csr_wdata = {$urandom, $urandom};
      wb_pc = $urandom;
      wb_next_pc = $urandom;
      csr_mtvec = {$urandom, $urandom};
      csr_mepc = {$urandom, $urandom};
      csr_mstatus = 64'($urandom_range(0, 1)) << 3;
      csr_mie = 64'($urandom_range(0, 1)) << 7;
      timer_irq = ($urandom_range(0, 9) < 3);
      redirect_ready = $urandom_range(0, 1) == 1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
